// File: rtl/fwd_scoreboard.sv
// ID-stage forwarding scoreboard: shadows in-flight writer tags and resolves source operands
// by byte-merging matching results over regfile data, stalling on not-yet-ready producers.
module fwd_scoreboard #(
    parameter int unsigned NSTAGE = 4,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NKEEP  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_flush,
    input  logic                  i_ds_valid,
    input  logic                  i_ds_go,
    input  logic [AW-1:0]         i_ds_dest,
    input  logic [DW/8-1:0]       i_ds_we,
    input  logic [NREAD-1:0]      i_rd_en,
    input  logic [NREAD*AW-1:0]   i_rd_addr,
    input  logic [NREAD*DW-1:0]   i_rf_rdata,
    input  logic [NSTAGE-1:0]     i_stage_adv,
    input  logic [NSTAGE-1:0]     i_stage_rdy,
    input  logic [NSTAGE*DW-1:0]  i_stage_result,
    output logic [NREAD*DW-1:0]   o_rd_value,
    output logic                  o_ds_stall,
    output logic [15:0]           o_stall_cnt
);

    localparam int unsigned NB = DW / 8;

    logic [NSTAGE-1:0] r_v;
    logic [AW-1:0]     r_dest [NSTAGE];
    logic [NB-1:0]     r_we   [NSTAGE];
    logic [15:0]       r_stall_cnt;

    logic [NSTAGE-1:0] w_v_d;
    logic [AW-1:0]     w_dest_d [NSTAGE];
    logic [NB-1:0]     w_we_d   [NSTAGE];
    logic              w_ds_accept;
    logic              w_stall;
    logic [NREAD*DW-1:0] w_rd_value;

    assign w_ds_accept = i_ds_go & ~w_stall;

    // Shadow pipeline next state; flush of the younger stages overrides both advance and issue.
    always_comb begin
        w_v_d = r_v;
        for (int k = 0; k < NSTAGE; k++) begin
            w_dest_d[k] = r_dest[k];
            w_we_d[k]   = r_we[k];
        end

        if (w_ds_accept) begin
            w_v_d[0]    = (|i_ds_we) && (i_ds_dest != '0);
            w_dest_d[0] = i_ds_dest;
            w_we_d[0]   = i_ds_we;
        end else if (i_stage_adv[0]) begin
            w_v_d[0] = 1'b0;
        end

        for (int k = 1; k < NSTAGE; k++) begin
            if (i_stage_adv[k-1]) begin
                w_v_d[k]    = r_v[k-1];
                w_dest_d[k] = r_dest[k-1];
                w_we_d[k]   = r_we[k-1];
            end else if (i_stage_adv[k]) begin
                w_v_d[k] = 1'b0;
            end
        end

        if (i_flush) begin
            for (int k = 0; k < NSTAGE - NKEEP; k++) begin
                w_v_d[k] = 1'b0;
            end
        end
    end

    // Walk oldest to youngest so the youngest matching writer owns each byte it enables.
    always_comb begin
        logic [DW-1:0] w_val;
        logic          w_match;
        w_stall    = 1'b0;
        w_rd_value = i_rf_rdata;
        for (int p = 0; p < NREAD; p++) begin
            w_val = i_rf_rdata[p*DW +: DW];
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                w_match = i_rd_en[p] && (i_rd_addr[p*AW +: AW] != '0) && r_v[k] &&
                          (r_dest[k] == i_rd_addr[p*AW +: AW]);
                if (w_match) begin
                    for (int b = 0; b < NB; b++) begin
                        if (r_we[k][b]) begin
                            w_val[b*8 +: 8] = i_stage_result[k*DW + b*8 +: 8];
                        end
                    end
                    if (!i_stage_rdy[k]) begin
                        w_stall = i_ds_valid;
                    end
                end
            end
            w_rd_value[p*DW +: DW] = w_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_v         <= '0;
            r_stall_cnt <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                r_dest[k] <= '0;
                r_we[k]   <= '0;
            end
        end else begin
            r_v <= w_v_d;
            for (int k = 0; k < NSTAGE; k++) begin
                r_dest[k] <= w_dest_d[k];
                r_we[k]   <= w_we_d[k];
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_rd_value  = w_rd_value;
    assign o_ds_stall  = w_stall;
    assign o_stall_cnt = r_stall_cnt;

    // Issuing into stage 0 while stalled is a pipeline-control bug upstream.
    a_go_while_stall : assert property (@(posedge i_clk) disable iff (!i_resetn)
                                        !(i_ds_go && w_stall));

endmodule
